// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters, registered sync and blank, a pix_en-gated delay line
// for the sync/blank copies, and a frame tick plus frame counter for animation sequencing.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        hs_d,
  output logic        vs_d,
  output logic        blank_d,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  HLast   = 10'(HTotal - 1);
  localparam logic [9:0]  VLast   = 10'(VTotal - 1);
  // 11-bit bounds so an edge that lands exactly on 1024 does not alias to 0
  localparam logic [10:0] HActive = 11'(H_ACTIVE);
  localparam logic [10:0] HsStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VActive = 11'(V_ACTIVE);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (HTotal > 1024 || VTotal > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H or V total exceeds the 10-bit counter range");
  end
  if (PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..7");
  end

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (pix_en) begin
      if (x_q == HLast) begin
        x_d = '0;
        if (y_q == VLast) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 16'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decoded from the next counts so the flags line up with the coordinates they describe
    hsync_d  = !(({1'b0, x_d} >= HsStart) && ({1'b0, x_d} < HsEnd));
    vsync_d  = !(({1'b0, y_d} >= VsStart) && ({1'b0, y_d} < VsEnd));
    active_d = ({1'b0, x_d} < HActive) && ({1'b0, y_d} < VActive);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b1;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign blank       = active_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

  if (PIPE_DLY == 0) begin : g_no_dly
    assign hs_d    = hsync_q;
    assign vs_d    = vsync_q;
    assign blank_d = active_q;
  end else begin : g_dly
    // Each stage holds {hs, vs, blank}; stages reset to "sync idle, not visible"
    logic [2:0] dly_q [PIPE_DLY];

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) begin
          dly_q[i] <= 3'b110;
        end
      end else if (pix_en) begin
        dly_q[0] <= {hsync_q, vsync_q, active_q};
        for (int i = 1; i < int'(PIPE_DLY); i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign {hs_d, vs_d, blank_d} = dly_q[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (delays 1/0/3 at VGA timing, delay 2 on a tiny raster)
// checked every cycle against an arithmetic model driven by the count of pixel advances.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic pix_en;

  always #5 clk = ~clk;

  logic [9:0]  dx [4];
  logic [9:0]  dy [4];
  logic        hs_w [4];
  logic        vs_w [4];
  logic        bl_w [4];
  logic        hsd_w [4];
  logic        vsd_w [4];
  logic        bld_w [4];
  logic        fs_w [4];
  logic [15:0] fc_w [4];

  int dly_tab [4] = '{1, 0, 3, 2};

  int checks = 0;
  int errors = 0;
  int n      = 0;   // pixel advances since reset release
  int off    = 0;   // frame counter preload offset (small instance)
  bit last_en = 1'b0;

  vga_timing_gen #(.PIPE_DLY(1)) u_dly1 (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx[0]), .DrawY(dy[0]),
    .blank(bl_w[0]), .hs(hs_w[0]), .vs(vs_w[0]), .hs_d(hsd_w[0]), .vs_d(vsd_w[0]),
    .blank_d(bld_w[0]), .frame_start(fs_w[0]), .frame_cnt(fc_w[0])
  );

  vga_timing_gen #(.PIPE_DLY(0)) u_dly0 (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx[1]), .DrawY(dy[1]),
    .blank(bl_w[1]), .hs(hs_w[1]), .vs(vs_w[1]), .hs_d(hsd_w[1]), .vs_d(vsd_w[1]),
    .blank_d(bld_w[1]), .frame_start(fs_w[1]), .frame_cnt(fc_w[1])
  );

  vga_timing_gen #(.PIPE_DLY(3)) u_dly3 (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx[2]), .DrawY(dy[2]),
    .blank(bl_w[2]), .hs(hs_w[2]), .vs(vs_w[2]), .hs_d(hsd_w[2]), .vs_d(vsd_w[2]),
    .blank_d(bld_w[2]), .frame_start(fs_w[2]), .frame_cnt(fc_w[2])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIPE_DLY(2)
  ) u_sml (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx[3]), .DrawY(dy[3]),
    .blank(bl_w[3]), .hs(hs_w[3]), .vs(vs_w[3]), .hs_d(hsd_w[3]), .vs_d(vsd_w[3]),
    .blank_d(bld_w[3]), .frame_start(fs_w[3]), .frame_cnt(fc_w[3])
  );

  // Raster position and flags after p pixel advances, from the timing table alone
  function automatic void raster(input bit sm, input int p, output logic [9:0] x,
                                 output logic [9:0] y, output logic h, output logic v,
                                 output logic b);
    int ht, vt, ha, hss, hse, va, vss, vse, xi, yi;
    if (sm) begin
      ht = 16;  vt = 11;  ha = 8;   hss = 10;  hse = 13;  va = 6;   vss = 7;   vse = 9;
    end else begin
      ht = 800; vt = 525; ha = 640; hss = 656; hse = 752; va = 480; vss = 490; vse = 492;
    end
    xi = p % ht;
    yi = (p / ht) % vt;
    x  = 10'(xi);
    y  = 10'(yi);
    h  = !(xi >= hss && xi < hse);
    v  = !(yi >= vss && yi < vse);
    b  = (xi < ha) && (yi < va);
  endfunction

  task automatic chk(input string tag, input int k, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[inst %0d] n=%0d: observed %0d expected %0d", tag, k, n, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [9:0] ex, ey, tx, ty;
    logic       eh, ev, eb, dh, dv, db;
    int         ft, fcx;
    bit         sm;
    for (int k = 0; k < 4; k++) begin
      sm = (k == 3);
      ft = sm ? 176 : 420000;
      raster(sm, n, ex, ey, eh, ev, eb);
      if (n < dly_tab[k]) begin
        {dh, dv, db} = 3'b110;
      end else begin
        raster(sm, n - dly_tab[k], tx, ty, dh, dv, db);
      end
      fcx = sm ? (n / ft + off) : (n / ft);
      chk("DrawX", k, 16'(dx[k]), 16'(ex));
      chk("DrawY", k, 16'(dy[k]), 16'(ey));
      chk("hs", k, 16'(hs_w[k]), 16'(eh));
      chk("vs", k, 16'(vs_w[k]), 16'(ev));
      chk("blank", k, 16'(bl_w[k]), 16'(eb));
      chk("hs_d", k, 16'(hsd_w[k]), 16'(dh));
      chk("vs_d", k, 16'(vsd_w[k]), 16'(dv));
      chk("blank_d", k, 16'(bld_w[k]), 16'(db));
      chk("frame_start", k, 16'(fs_w[k]), 16'(last_en && n > 0 && (n % ft) == 0));
      chk("frame_cnt", k, fc_w[k], 16'(fcx));
    end
  endtask

  // Called at a falling edge: drive pix_en, take one rising edge, sample at the next falling edge
  task automatic tick(input logic en);
    pix_en = en;
    @(posedge clk);
    if (en) n++;
    last_en = en;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int low_cnt, first_low;
    reset_n = 1'b0;
    pix_en  = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;
    check_all();

    // Full-speed pixels over the first line: hs low width and position
    low_cnt   = 0;
    first_low = -1;
    for (int i = 0; i < 800; i++) begin
      tick(1'b1);
      if (hs_w[0] === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(dx[0]);
      end
    end
    chk("hs_low_width_full", 0, 16'(low_cnt), 16'd96);
    chk("hs_low_start_x", 0, 16'(first_low), 16'd656);
    for (int i = 0; i < 800; i++) tick(1'b1);

    // Alternating pix_en over one line: every pixel lasts two clocks
    low_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      tick((i % 2) == 0);
      if (hs_w[0] === 1'b0) low_cnt++;
    end
    chk("hs_low_width_half", 0, 16'(low_cnt), 16'd192);

    // Random pixel enables
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 3) != 0);

    // Preload the small instance's frame counter to 65535 mid-frame, then run through the wrap
    while ((n % 176) != 50) tick(1'b1);
    force u_sml.frame_cnt_q = 16'hffff;
    off = 65535 - n / 176;
    for (int i = 0; i < 5; i++) tick(1'b1);
    release u_sml.frame_cnt_q;
    while ((n % 176) != 0) tick(1'b1);
    chk("wrap_frame_cnt", 3, fc_w[3], 16'd0);
    chk("wrap_frame_start", 3, 16'(fs_w[3]), 16'd1);
    for (int i = 0; i < 200; i++) tick($urandom_range(0, 1) != 0);

    // Asynchronous reset mid-frame, away from any clock edge
    while ((n % 176) < 40) tick(1'b1);
    pix_en = 1'b1;
    #2;
    reset_n = 1'b0;
    n       = 0;
    off     = 0;
    last_en = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    tick(1'b1);
    chk("post_reset_x", 3, 16'(dx[3]), 16'd1);
    chk("post_reset_fs", 3, 16'(fs_w[3]), 16'd0);
    for (int i = 0; i < 400; i++) tick($urandom_range(0, 4) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
